mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Initiator side of the single-port data-memory interface (8b data, 8b addr,
//  comb. read, clocked write on wr_en). Accepts load/store/push/pop/copy
//  requests from the core over a valid/ready handshake, sequences memory-port
//  cycles, keeps the stack pointer, and returns results on a 1-cycle response
//  strobe. Sits between the processor control path and the data memory.
// PARAMETERS
//  SP_INIT   8'd255  stack pointer reset value; stack empty when sp==SP_INIT
//  SP_LIMIT  8'd191  lowest sp; PUSH refused when sp==SP_LIMIT (64 entries)
// PORTS
//  clk          in   1  single clock; all state updates on posedge
//  reset        in   1  synchronous, active-high
//  req_valid    in   1  request present
//  req_ready    out  1  high only in IDLE; transfer when valid&&ready
//  req_op       in   3  0 LOAD, 1 STORE, 2 PUSH, 3 POP, 4 COPY; 5-7 illegal
//  req_addr     in   8  LOAD/STORE address; COPY source
//  req_data     in   8  STORE/PUSH data; COPY destination
//  req_len      in   8  COPY byte count (0 allowed)
//  rsp_valid    out  1  one-cycle completion strobe, every accepted request
//  rsp_data     out  8  LOAD/POP result; 0 for all other ops and on error
//  rsp_err      out  1  qualified by rsp_valid: overflow/underflow/illegal op
//  sp           out  8  current stack pointer (next free slot)
//  busy         out  1  ~req_ready
//  mem_addr     out  8  memory address
//  mem_wr_en    out  1  memory write enable
//  mem_dat_in   out  8  memory write data
//  mem_dat_out  in   8  memory read data (combinational from mem_addr)
// BEHAVIOUR
//  - Reset: state=IDLE, sp=SP_INIT, rsp_valid=0, rsp_data=0, rsp_err=0,
//    mem_wr_en=0, mem_addr=0, mem_dat_in=0. Memory contents untouched.
//  - mem_wr_en is combinationally forced 0 while reset=1: reset in any state,
//    incl. mid-COPY, aborts with no further writes; partial copy stays.
//  - FSM: IDLE -> EXEC -> RESP -> IDLE; COPY: IDLE -> CP_RD <-> CP_WR -> RESP.
//  - IDLE: req_ready=1; on handshake latch op/addr/data/len (cycle N).
//  - EXEC (N+1): mem_addr driven. STORE: wr_en=1, dat=req_data at addr.
//    LOAD: capture mem_dat_out at end of cycle. PUSH: write req_data at sp,
//    sp<=sp-1. POP: mem_addr=sp+1, capture, sp<=sp+1.
//  - RESP (N+2): rsp_valid=1 exactly one cycle. Back-to-back request
//    accepted at earliest N+3. Latency accept->rsp_valid = 2 cycles.
//  - Errors (checked in EXEC, no write, sp unchanged, rsp_err=1, rsp_data=0):
//    PUSH with sp==SP_LIMIT; POP with sp==SP_INIT; op 5-7.
//  - COPY: src=req_addr, dst=req_data, cnt=req_len. cnt==0 -> RESP directly
//    (rsp at N+2, no mem_wr_en). Else per byte: CP_RD mem_addr=src, capture
//    into buffer; CP_WR mem_addr=dst, wr_en=1, src++, dst++, cnt--; cnt==0
//    after write -> RESP. 2 cycles/byte; rsp_valid at N+1+2*len.
//  - All address arithmetic 8-bit modulo 256 (src/dst/sp wrap silently).
//    Overlapping src/dst copied strictly ascending, byte at a time.
//  - mem_wr_en high only in EXEC(STORE/PUSH ok) and CP_WR; mem_addr/mem_dat_in
//    held at last value otherwise (no X on the port).
// STRUCTURE
//  - mem_if_pkg: op enum (LOAD..COPY), state enum, SP_INIT/SP_LIMIT defaults.
//  - Single module; no sub-module (FSM + sp + copy counters fit one file).
// TESTING (bench models memory as 256x8 comb-read/clocked-write array)
//  1 Reset, LOAD addr 69 -> rsp_valid at N+2, rsp_data=8'h7F, err=0.
//  2 STORE 0xA5@100, then LOAD 100 -> 0xA5; wr_en high exactly one cycle.
//  3 PUSH 0x11,0x22 -> sp 255->253; POP,POP -> 0x22,0x11, sp=255;
//    3rd POP -> rsp_err=1, rsp_data=0, sp=255.
//  4 64 PUSHes ok, 65th -> rsp_err=1, sp=191, mem[191] unchanged.
//  5 COPY src=60 dst=200 len=13 -> mem[200..212]=mem[60..72], rsp at N+27;
//    len=0 -> rsp at N+2, no write; src=250 len=10 wraps to 0..3.
//  6 Reset asserted in 3rd CP_WR of len=8 copy -> only 2 bytes written,
//    no wr_en during reset, IDLE/sp=255 next cycle; req_ready=1.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types and defaults for the data-memory access unit.
// Opcode and FSM state encodings live here so the core side and the bench agree.
package mem_access_unit_pkg;

   localparam logic [7:0] SP_INIT_DEF  = 8'd255;
   localparam logic [7:0] SP_LIMIT_DEF = 8'd191;

   typedef enum logic [2:0] {
      OP_LOAD  = 3'd0,
      OP_STORE = 3'd1,
      OP_PUSH  = 3'd2,
      OP_POP   = 3'd3,
      OP_COPY  = 3'd4
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_EXEC  = 3'd1,
      S_RESP  = 3'd2,
      S_CP_RD = 3'd3,
      S_CP_WR = 3'd4
   } state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// Core-side request/response bus of the memory access unit.
// The core is the master; the access unit is the slave.
interface mem_access_unit_if;

   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_op;
   logic [7:0] req_addr;
   logic [7:0] req_data;
   logic [7:0] req_len;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_err;
   logic [7:0] sp;
   logic       busy;

   modport master (
      output req_valid, req_op, req_addr, req_data, req_len,
      input  req_ready, rsp_valid, rsp_data, rsp_err, sp, busy
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_data, req_len,
      output req_ready, rsp_valid, rsp_data, rsp_err, sp, busy
   );

endinterface

// File: rtl/mem_access_unit.sv
// Initiator for the single-port data memory: sequences load/store/push/pop/copy
// requests into memory cycles, owns the stack pointer and strobes one response per request.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter logic [7:0] SP_INIT  = SP_INIT_DEF,
   parameter logic [7:0] SP_LIMIT = SP_LIMIT_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   mem_access_unit_if.slave        bus,
   output logic [7:0]              mem_addr,
   output logic                    mem_wr_en,
   output logic [7:0]              mem_dat_in,
   input  logic [7:0]              mem_dat_out
);

   state_e     state, state_nxt;
   logic [2:0] op;
   logic [7:0] sp_r;
   logic [7:0] src, dst, cnt;
   logic [7:0] addr_r, wdat_r;
   logic [7:0] rsp_data_r;
   logic       rsp_err_r;
   logic       ready, rsp_v, wr;
   logic       push_ok;

   assign push_ok = (op == OP_PUSH) && (sp_r != SP_LIMIT);

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (bus.req_valid) begin
               // Zero-length copy takes the plain EXEC path so it answers at N+2.
               if ((bus.req_op == OP_COPY) && (bus.req_len != 8'd0)) state_nxt = S_CP_RD;
               else                                                   state_nxt = S_EXEC;
            end
         end
         S_EXEC:  state_nxt = S_RESP;
         S_CP_RD: state_nxt = S_CP_WR;
         S_CP_WR: state_nxt = (cnt == 8'd1) ? S_RESP : S_CP_RD;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      ready = 1'b0;
      rsp_v = 1'b0;
      wr    = 1'b0;
      case (state)
         S_IDLE:  ready = 1'b1;
         S_EXEC:  wr    = (op == OP_STORE) || push_ok;
         S_CP_WR: wr    = 1'b1;
         S_RESP:  rsp_v = 1'b1;
         default: ;
      endcase
      // Reset kills any in-flight write immediately, even mid-copy.
      if (reset) wr = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op         <= 3'd0;
         sp_r       <= SP_INIT;
         src        <= 8'd0;
         dst        <= 8'd0;
         cnt        <= 8'd0;
         addr_r     <= 8'd0;
         wdat_r     <= 8'd0;
         rsp_data_r <= 8'd0;
         rsp_err_r  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  op         <= bus.req_op;
                  src        <= bus.req_addr;
                  dst        <= bus.req_data;
                  cnt        <= bus.req_len;
                  rsp_data_r <= 8'd0;
                  rsp_err_r  <= 1'b0;
                  case (bus.req_op)
                     OP_LOAD, OP_STORE: begin
                        addr_r <= bus.req_addr;
                        wdat_r <= bus.req_data;
                     end
                     OP_PUSH: begin
                        addr_r <= sp_r;
                        wdat_r <= bus.req_data;
                     end
                     OP_POP:  addr_r <= sp_r + 8'd1;
                     OP_COPY: if (bus.req_len != 8'd0) addr_r <= bus.req_addr;
                     default: ;
                  endcase
               end
            end
            S_EXEC: begin
               case (op)
                  OP_LOAD: rsp_data_r <= mem_dat_out;
                  OP_PUSH: begin
                     if (sp_r == SP_LIMIT) rsp_err_r <= 1'b1;
                     else                  sp_r      <= sp_r - 8'd1;
                  end
                  OP_POP: begin
                     if (sp_r == SP_INIT) rsp_err_r <= 1'b1;
                     else begin
                        rsp_data_r <= mem_dat_out;
                        sp_r       <= sp_r + 8'd1;
                     end
                  end
                  OP_STORE, OP_COPY: ;
                  default: rsp_err_r <= 1'b1;
               endcase
            end
            S_CP_RD: begin
               // The write-data register doubles as the one-byte copy buffer.
               wdat_r <= mem_dat_out;
               addr_r <= dst;
            end
            S_CP_WR: begin
               src    <= src + 8'd1;
               dst    <= dst + 8'd1;
               cnt    <= cnt - 8'd1;
               addr_r <= src + 8'd1;
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready = ready;
   assign bus.busy      = ~ready;
   assign bus.rsp_valid = rsp_v;
   assign bus.rsp_data  = rsp_data_r;
   assign bus.rsp_err   = rsp_err_r;
   assign bus.sp        = sp_r;
   assign mem_addr      = addr_r;
   assign mem_dat_in    = wdat_r;
   assign mem_wr_en     = wr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, push-overflow and reset-mid-copy
// sequences, then random requests checked against an array-based memory/stack model.
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   logic       clk;
   logic       reset;
   logic       load_mem;
   logic [7:0] mem_addr;
   logic       mem_wr_en;
   logic [7:0] mem_dat_in;
   logic [7:0] mem_dat_out;
   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];
   logic [7:0] ref_sp;

   int total = 0;
   int bad   = 0;

   mem_access_unit_if bus ();

   mem_access_unit dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .mem_addr    (mem_addr),
      .mem_wr_en   (mem_wr_en),
      .mem_dat_in  (mem_dat_in),
      .mem_dat_out (mem_dat_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_dat_out = mem[mem_addr];

   always @(posedge clk) begin
      if (load_mem) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h3A;
      end else if (mem_wr_en) begin
         mem[mem_addr] <= mem_dat_in;
      end
   end

   typedef struct {
      logic [2:0] op;
      logic [7:0] addr;
      logic [7:0] data;
      logic [7:0] len;
      logic [7:0] d;
      logic       e;
      logic [7:0] sp;
      int         lat;
      int         wr;
   } vec_t;

   vec_t tbl [18];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Specification-level model: memory as an array, stack as a pointer, copy as a loop.
   task automatic model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] dt,
                        input logic [7:0] ln, output logic [7:0] d, output logic e,
                        output int lat, output int wr);
      d = 8'd0; e = 1'b0; lat = 2; wr = 0;
      case (op)
         3'd0: d = ref_mem[a];
         3'd1: begin ref_mem[a] = dt; wr = 1; end
         3'd2: begin
            if (ref_sp == 8'd191) e = 1'b1;
            else begin ref_mem[ref_sp] = dt; ref_sp = ref_sp - 8'd1; wr = 1; end
         end
         3'd3: begin
            if (ref_sp == 8'd255) e = 1'b1;
            else begin ref_sp = ref_sp + 8'd1; d = ref_mem[ref_sp]; end
         end
         3'd4: begin
            for (int i = 0; i < int'(ln); i++)
               ref_mem[(int'(dt) + i) % 256] = ref_mem[(int'(a) + i) % 256];
            lat = (ln == 8'd0) ? 2 : 1 + 2 * int'(ln);
            wr  = int'(ln);
         end
         default: e = 1'b1;
      endcase
   endtask

   // Starts at a negedge, returns at the negedge after the response strobe.
   task automatic do_req(input logic [2:0] op, input logic [7:0] a, input logic [7:0] dt,
                         input logic [7:0] ln, output logic [7:0] d, output logic e,
                         output logic [7:0] sp_a, output int lat, output int wr);
      int  w;
      bit  got;
      d = 8'd0; e = 1'b0; sp_a = 8'd0; lat = 0; wr = 0; got = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_addr  = a;
      bus.req_data  = dt;
      bus.req_len   = ln;
      w = 0;
      while (!bus.req_ready && w < 20) begin @(negedge clk); w++; end
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      while (!got && lat < 600) begin
         @(negedge clk);
         lat++;
         if (mem_wr_en) wr++;
         if (bus.rsp_valid) begin
            got = 1'b1;
            d   = bus.rsp_data;
            e   = bus.rsp_err;
         end
      end
      chk("rsp_seen", int'(got), 1);
      @(negedge clk);
      sp_a = bus.sp;
      chk("rsp_one_cycle", int'(bus.rsp_valid), 0);
      chk("ready_after_rsp", int'(bus.req_ready), 1);
   endtask

   logic [7:0] gd, md, gsp, saved;
   logic       ge, me;
   int         glat, gwr, mlat, mwr, errs, wseen, cyc, diffs;
   logic [2:0] rop;
   int         r;

   initial begin
      tbl[0]  = '{3'd0, 8'd69,  8'd0,    8'd0,  8'h7F, 1'b0, 8'd255, 2,  0};
      tbl[1]  = '{3'd1, 8'd100, 8'hA5,   8'd0,  8'h00, 1'b0, 8'd255, 2,  1};
      tbl[2]  = '{3'd0, 8'd100, 8'd0,    8'd0,  8'hA5, 1'b0, 8'd255, 2,  0};
      tbl[3]  = '{3'd2, 8'd0,   8'h11,   8'd0,  8'h00, 1'b0, 8'd254, 2,  1};
      tbl[4]  = '{3'd2, 8'd0,   8'h22,   8'd0,  8'h00, 1'b0, 8'd253, 2,  1};
      tbl[5]  = '{3'd3, 8'd0,   8'd0,    8'd0,  8'h22, 1'b0, 8'd254, 2,  0};
      tbl[6]  = '{3'd3, 8'd0,   8'd0,    8'd0,  8'h11, 1'b0, 8'd255, 2,  0};
      tbl[7]  = '{3'd3, 8'd0,   8'd0,    8'd0,  8'h00, 1'b1, 8'd255, 2,  0};
      tbl[8]  = '{3'd5, 8'd7,   8'd9,    8'd0,  8'h00, 1'b1, 8'd255, 2,  0};
      tbl[9]  = '{3'd7, 8'd7,   8'd9,    8'd0,  8'h00, 1'b1, 8'd255, 2,  0};
      tbl[10] = '{3'd4, 8'd60,  8'd200,  8'd13, 8'h00, 1'b0, 8'd255, 27, 13};
      tbl[11] = '{3'd4, 8'd10,  8'd20,   8'd0,  8'h00, 1'b0, 8'd255, 2,  0};
      tbl[12] = '{3'd4, 8'd250, 8'd30,   8'd10, 8'h00, 1'b0, 8'd255, 21, 10};
      tbl[13] = '{3'd0, 8'd205, 8'd0,    8'd0,  8'h7B, 1'b0, 8'd255, 2,  0};
      tbl[14] = '{3'd0, 8'd31,  8'd0,    8'd0,  8'hC1, 1'b0, 8'd255, 2,  0};
      tbl[15] = '{3'd0, 8'd38,  8'd0,    8'd0,  8'h38, 1'b0, 8'd255, 2,  0};
      tbl[16] = '{3'd0, 8'd20,  8'd0,    8'd0,  8'h2E, 1'b0, 8'd255, 2,  0};
      tbl[17] = '{3'd0, 8'd212, 8'd0,    8'd0,  8'h72, 1'b0, 8'd255, 2,  0};

      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h3A;
      ref_sp = 8'd255;

      bus.req_valid = 1'b0;
      bus.req_op    = 3'd0;
      bus.req_addr  = 8'd0;
      bus.req_data  = 8'd0;
      bus.req_len   = 8'd0;
      reset    = 1'b1;
      load_mem = 1'b1;
      repeat (3) @(negedge clk);
      load_mem = 1'b0;
      chk("rst_ready", int'(bus.req_ready), 1);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
      chk("rst_rsp_data", int'(bus.rsp_data), 0);
      chk("rst_rsp_err", int'(bus.rsp_err), 0);
      chk("rst_sp", int'(bus.sp), 255);
      chk("rst_wr_en", int'(mem_wr_en), 0);
      chk("rst_mem_addr", int'(mem_addr), 0);
      chk("rst_mem_dat_in", int'(mem_dat_in), 0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 18; i++) begin
         do_req(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].len, gd, ge, gsp, glat, gwr);
         model(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].len, md, me, mlat, mwr);
         chk($sformatf("v%0d_data", i), int'(gd), int'(tbl[i].d));
         chk($sformatf("v%0d_err", i), int'(ge), int'(tbl[i].e));
         chk($sformatf("v%0d_sp", i), int'(gsp), int'(tbl[i].sp));
         chk($sformatf("v%0d_lat", i), glat, tbl[i].lat);
         chk($sformatf("v%0d_wr", i), gwr, tbl[i].wr);
      end
      diffs = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
      chk("mem_after_table", diffs, 0);

      // Fill the stack to its 64-entry limit, then one more push must be refused.
      errs = 0;
      for (int i = 0; i < 64; i++) begin
         do_req(3'd2, 8'd0, 8'(i + 1), 8'd0, gd, ge, gsp, glat, gwr);
         model(3'd2, 8'd0, 8'(i + 1), 8'd0, md, me, mlat, mwr);
         if (ge !== 1'b0 || gwr != 1) errs++;
      end
      chk("push64_errors", errs, 0);
      chk("push64_sp", int'(bus.sp), 191);
      saved = mem[191];
      do_req(3'd2, 8'd0, 8'hEE, 8'd0, gd, ge, gsp, glat, gwr);
      model(3'd2, 8'd0, 8'hEE, 8'd0, md, me, mlat, mwr);
      chk("push65_err", int'(ge), 1);
      chk("push65_data", int'(gd), 0);
      chk("push65_sp", int'(gsp), 191);
      chk("push65_wr", gwr, 0);
      chk("push65_mem191", int'(mem[191]), int'(saved));

      // Reset lands in the third write cycle of an 8-byte copy.
      saved = mem[122];
      bus.req_valid = 1'b1;
      bus.req_op    = 3'd4;
      bus.req_addr  = 8'd10;
      bus.req_data  = 8'd120;
      bus.req_len   = 8'd8;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      wseen = 0;
      cyc   = 0;
      while (wseen < 3 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (mem_wr_en) wseen++;
      end
      chk("cp_third_write_seen", wseen, 3);
      reset = 1'b1;
      #1 chk("cp_wr_en_in_reset", int'(mem_wr_en), 0);
      @(posedge clk);
      #1;
      chk("cp_rst_ready", int'(bus.req_ready), 1);
      chk("cp_rst_sp", int'(bus.sp), 255);
      chk("cp_rst_rsp_valid", int'(bus.rsp_valid), 0);
      chk("cp_rst_mem_addr", int'(mem_addr), 0);
      @(negedge clk);
      reset = 1'b0;
      ref_mem[120] = ref_mem[10];
      ref_mem[121] = ref_mem[11];
      ref_sp = 8'd255;
      chk("cp_byte0", int'(mem[120]), int'(ref_mem[10]));
      chk("cp_byte1", int'(mem[121]), int'(ref_mem[11]));
      chk("cp_byte2_untouched", int'(mem[122]), int'(saved));
      @(negedge clk);

      for (int n = 0; n < 250; n++) begin
         r = $urandom_range(0, 99);
         if      (r < 20) rop = 3'd0;
         else if (r < 35) rop = 3'd1;
         else if (r < 60) rop = 3'd2;
         else if (r < 80) rop = 3'd3;
         else if (r < 95) rop = 3'd4;
         else             rop = 3'($urandom_range(5, 7));
         begin
            logic [7:0] a, dt, ln;
            a  = 8'($urandom_range(0, 255));
            dt = 8'($urandom_range(0, 255));
            ln = 8'($urandom_range(0, 12));
            do_req(rop, a, dt, ln, gd, ge, gsp, glat, gwr);
            model(rop, a, dt, ln, md, me, mlat, mwr);
         end
         chk("rand_data", int'(gd), int'(md));
         chk("rand_err", int'(ge), int'(me));
         chk("rand_sp", int'(gsp), int'(ref_sp));
         chk("rand_lat", glat, mlat);
         chk("rand_wr", gwr, mwr);
      end
      diffs = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
      chk("mem_after_random", diffs, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
